// File: rtl/rs_pkg.sv
// Shared definitions for the GF(2^5) Reed-Solomon encoder.
//   SYM_W/N/K/NPAR : symbol width and code geometry (RS(31,27), t = 2)
//   PRIM_POLY      : field polynomial x^5 + x^2 + 1
//   GEN            : generator coefficients, GEN[i] multiplies x^i.
//                    g(x) = (x+1)(x+a)(x+a^2)(x+a^3), monic x^4 term implied.
//   gf_mul         : general GF(32) multiply (shift-and-add with reduction)
package rs_pkg;

  localparam int SYM_W = 5;
  localparam int N     = 31;
  localparam int K     = 27;
  localparam int NPAR  = N - K;
  localparam int FCR   = 0;

  localparam logic [SYM_W:0] PRIM_POLY = 6'b100101;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } enc_state_t;

  // g(x) = x^4 + 15 x^3 + 19 x^2 + 23 x + 10
  localparam sym_t GEN [0:NPAR-1] = '{5'd10, 5'd23, 5'd19, 5'd15};

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      // multiply running term by alpha, folding x^5 back as x^2 + 1
      sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf32_const_mul.sv
// Combinational multiply of a GF(2^5) symbol by a fixed coefficient.
//   COEF : constant multiplier
//   a    : input symbol
//   p    : a * COEF
// With COEF fixed the multiply collapses to a small XOR network.
module gf32_const_mul
  import rs_pkg::*;
#(
  parameter sym_t COEF = 5'd1
) (
  input  logic [SYM_W-1:0] a,
  output logic [SYM_W-1:0] p
);

  assign p = gf_mul(a, COEF);

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(31,27) encoder over GF(2^5).
// Message symbols are forwarded unchanged; four parity symbols from an
// LFSR polynomial divider follow directly after the last message symbol.
//   clock2    : system clock, rising edge
//   reset     : asynchronous active-low reset
//   in_start  : marks first message symbol of a codeword (with in_valid)
//   in_valid  : in_sym carries a message symbol
//   in_sym    : message symbol, highest-degree coefficient first
//   in_ready  : encoder accepts a symbol this cycle
//   out_valid : out_sym carries a codeword symbol
//   out_sym   : codeword symbol (27 message, then 4 parity)
//   out_first : codeword symbol 0
//   out_last  : codeword symbol 30
//   busy      : codeword in progress
//
// state  | meaning
// IDLE   | waiting for a start-qualified transfer; other transfers dropped
// DATA   | accepting message symbols 1..K-1, dividing through the LFSR
// PARITY | input stalled, draining the LFSR one parity symbol per cycle
module rs_encoder
  import rs_pkg::*;
(
  input  logic             clock2,
  input  logic             reset,
  input  logic             in_start,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_sym,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);

  localparam logic [4:0] LAST_DATA = 5'(K - 1);
  localparam logic [4:0] LAST_PAR  = 5'(NPAR - 1);

  enc_state_t state, state_nxt;
  logic [4:0] count, count_nxt;

  sym_t lfsr     [NPAR];
  sym_t lfsr_nxt [NPAR];
  sym_t prod     [NPAR];
  sym_t fb;

  logic lfsr_en;
  logic out_load;
  sym_t sym_nxt;
  logic first_nxt;
  logic last_nxt;
  logic xfer;

  assign in_ready = (state != PARITY);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid & in_ready;

  // During PARITY the feedback is forced to zero, so the same update
  // equation degenerates into a plain shift that drains the remainder.
  assign fb = (state == PARITY) ? '0 : (in_sym ^ lfsr[NPAR-1]);

  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    gf32_const_mul #(.COEF(GEN[i])) u_mul (
      .a (fb),
      .p (prod[i])
    );
  end

  always_comb begin
    lfsr_nxt[0] = prod[0];
    for (int i = 1; i < NPAR; i++) begin
      lfsr_nxt[i] = lfsr[i-1] ^ prod[i];
    end
  end

  always_ff @(posedge clock2 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    lfsr_en   = 1'b0;
    out_load  = 1'b0;
    sym_nxt   = out_sym;
    first_nxt = 1'b0;
    last_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (xfer && in_start) begin
          state_nxt = DATA;
          count_nxt = 5'd1;
          lfsr_en   = 1'b1;
          out_load  = 1'b1;
          sym_nxt   = in_sym;
          first_nxt = 1'b1;
        end
      end

      DATA: begin
        // in_start here is a protocol error; the symbol is simply data.
        if (xfer) begin
          lfsr_en  = 1'b1;
          out_load = 1'b1;
          sym_nxt  = in_sym;
          if (count == LAST_DATA) begin
            state_nxt = PARITY;
            count_nxt = '0;
          end else begin
            count_nxt = count + 5'd1;
          end
        end
      end

      PARITY: begin
        lfsr_en  = 1'b1;
        out_load = 1'b1;
        sym_nxt  = lfsr[NPAR-1];
        if (count == LAST_PAR) begin
          last_nxt  = 1'b1;
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + 5'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock2 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NPAR; i++) begin
        lfsr[i] <= '0;
      end
    end else if (lfsr_en) begin
      for (int i = 0; i < NPAR; i++) begin
        lfsr[i] <= lfsr_nxt[i];
      end
    end
  end

  always_ff @(posedge clock2 or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_sym   <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= out_load;
      out_sym   <= sym_nxt;
      out_first <= first_nxt;
      out_last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// Self-checking bench for rs_encoder: randomized messages checked against a
// polynomial-division reference built from log/antilog tables, plus
// syndrome evaluation of every observed codeword.
module tb_rs_encoder;

  localparam int TN = 31;
  localparam int TK = 27;
  localparam int TP = 4;

  typedef logic [4:0] msg_t [TK];
  typedef logic [4:0] cw_t  [TN];

  typedef struct {
    logic [4:0] sym;
    logic       first;
    logic       last;
    int         c;
  } obs_t;

  logic       clock2 = 1'b0;
  logic       reset = 1'b0;
  logic       in_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] in_sym = '0;
  logic       in_ready;
  logic       out_valid;
  logic [4:0] out_sym;
  logic       out_first;
  logic       out_last;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_low = 0;

  obs_t obs_q[$];

  int gexp [0:30];
  int glog [0:31];
  logic [4:0] gpoly [0:TP];

  msg_t saved_msg;
  cw_t  saved_cw;

  rs_encoder dut (
    .clock2    (clock2),
    .reset     (reset),
    .in_start  (in_start),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sym   (out_sym),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clock2 = ~clock2;

  always @(posedge clock2) cyc++;

  always @(negedge clock2) begin : collect
    obs_t o;
    if (reset) begin
      if (out_valid) begin
        o.sym   = out_sym;
        o.first = out_first;
        o.last  = out_last;
        o.c     = cyc;
        obs_q.push_back(o);
      end
      if (!in_ready) ready_low++;
    end
  end

  // ---------------- reference model ----------------
  function automatic int gm(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 31];
  endfunction

  task automatic build_field();
    int e;
    e = 1;
    for (int i = 0; i < 31; i++) begin
      gexp[i] = e;
      glog[e] = i;
      e = e << 1;
      if ((e & 32) != 0) e = e ^ 37;
    end
    glog[0] = 0;
    // g(x) = prod (x + alpha^i), i = 0..3; gpoly index = degree
    for (int j = 0; j <= TP; j++) gpoly[j] = '0;
    gpoly[0] = 5'd1;
    for (int i = 0; i < TP; i++) begin
      for (int j = TP; j >= 0; j--) begin
        gpoly[j] = 5'((j > 0 ? int'(gpoly[j-1]) : 0) ^ gm(int'(gpoly[j]), gexp[i]));
      end
    end
  endtask

  function automatic cw_t ref_encode(input msg_t m);
    cw_t r;
    int coef;
    for (int k = 0; k < TN; k++) r[k] = (k < TK) ? m[k] : 5'd0;
    for (int i = 0; i < TK; i++) begin
      coef = int'(r[i]);
      if (coef != 0) begin
        for (int j = 1; j <= TP; j++) begin
          r[i+j] = 5'(int'(r[i+j]) ^ gm(coef, int'(gpoly[TP-j])));
        end
      end
    end
    for (int k = 0; k < TK; k++) r[k] = m[k];
    return r;
  endfunction

  function automatic int syndrome(input cw_t cw, input int i);
    int s;
    s = 0;
    for (int k = 0; k < TN; k++) s = gm(s, gexp[i % 31]) ^ int'(cw[k]);
    return s;
  endfunction

  function automatic msg_t rand_msg();
    msg_t m;
    for (int k = 0; k < TK; k++) m[k] = 5'($urandom_range(31, 0));
    return m;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    in_valid = 1'b0;
    in_start = 1'b0;
    in_sym   = '0;
    reset    = 1'b0;
    repeat (3) @(negedge clock2);
    reset = 1'b1;
    @(negedge clock2);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock2);
      in_valid = 1'b0;
      in_start = 1'b0;
    end
  endtask

  // Leaves the final symbol driven; callers follow with idle() or another drive.
  task automatic drive(input msg_t m, input bit gaps, input int err_idx, input int nsym);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < nsym && guard < 2000) begin
      @(negedge clock2);
      guard++;
      if (gaps && $urandom_range(1, 0) == 0) begin
        in_valid = 1'b0;
        in_start = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_start = (idx == 0) || (idx == err_idx);
        in_sym   = m[idx];
        if (in_ready) idx++;
      end
    end
    checks++;
    if (idx < nsym) begin
      errors++;
      $display("FAIL drive_timeout: transferred %0d required %0d", idx, nsym);
    end
  endtask

  task automatic wait_obs(input int n);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 400) begin
      @(negedge clock2);
      t++;
    end
    #1;
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL wait_obs: got %0d symbols required %0d", obs_q.size(), n);
      while (obs_q.size() < n) obs_q.push_back('{sym: 5'h1f, first: 1'b0, last: 1'b0, c: 0});
    end
  endtask

  task automatic check_cw(input string name, input int base, input cw_t expv);
    cw_t got;
    int bad;
    int fbad;
    int lbad;
    int s;
    bad = -1;
    fbad = -1;
    lbad = -1;
    for (int k = 0; k < TN; k++) begin
      got[k] = obs_q[base+k].sym;
      if (got[k] !== expv[k] && bad < 0) bad = k;
      if (obs_q[base+k].first !== (k == 0) && fbad < 0) fbad = k;
      if (obs_q[base+k].last !== (k == TN - 1) && lbad < 0) lbad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_sym: index %0d got %0h expected %0h", name, bad, got[bad], expv[bad]);
    end
    checks++;
    if (fbad >= 0) begin
      errors++;
      $display("FAIL %s_first: index %0d got %0b expected %0b", name, fbad,
               obs_q[base+fbad].first, (fbad == 0));
    end
    checks++;
    if (lbad >= 0) begin
      errors++;
      $display("FAIL %s_last: index %0d got %0b expected %0b", name, lbad,
               obs_q[base+lbad].last, (lbad == TN - 1));
    end
    for (int i = 0; i < TP; i++) begin
      s = syndrome(got, i);
      checks++;
      if (s != 0) begin
        errors++;
        $display("FAIL %s_syndrome%0d: got %0h expected 0", name, i, s);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sym !== 5'd0) begin errors++; $display("FAIL reset_out_sym: got %h expected 0", out_sym); end
    checks++; if (out_first !== 1'b0) begin errors++; $display("FAIL reset_out_first: got %b expected 0", out_first); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    do_reset();
  endtask

  task automatic test_idle_drop();
    obs_q.delete();
    repeat (3) begin
      @(negedge clock2);
      in_valid = 1'b1;
      in_start = 1'b0;
      in_sym   = 5'($urandom_range(31, 1));
    end
    idle(3);
    #1;
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL idle_drop_out: got %0d symbols expected 0", obs_q.size()); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_drop_busy: got %b expected 0", busy); end
  endtask

  task automatic test_zero_msg();
    msg_t m;
    cw_t expv;
    for (int k = 0; k < TK; k++) m[k] = '0;
    expv = ref_encode(m);
    obs_q.delete();
    drive(m, 1'b0, -1, TK);
    idle(8);
    wait_obs(TN);
    checks++;
    if (obs_q.size() != TN) begin errors++; $display("FAIL zero_count: got %0d expected %0d", obs_q.size(), TN); end
    check_cw("zero", 0, expv);
  endtask

  task automatic test_unit_msg();
    msg_t m;
    logic [4:0] lit [TP];
    int bad;
    lit = '{5'd15, 5'd19, 5'd23, 5'd10};
    for (int k = 0; k < TK; k++) m[k] = '0;
    m[TK-1] = 5'd1;
    obs_q.delete();
    drive(m, 1'b0, -1, TK);
    idle(8);
    wait_obs(TN);
    bad = -1;
    for (int j = 0; j < TP; j++) if (obs_q[TK+j].sym !== lit[j] && bad < 0) bad = j;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL unit_parity: parity %0d got %0h expected %0h", bad, obs_q[TK+bad].sym, lit[bad]);
    end
    check_cw("unit", 0, ref_encode(m));
  endtask

  task automatic test_random();
    msg_t m;
    for (int r = 0; r < 3; r++) begin
      m = rand_msg();
      obs_q.delete();
      // last round also raises in_start mid-message; it must be treated as data
      drive(m, 1'b0, (r == 2) ? 5 : -1, TK);
      idle(8);
      wait_obs(TN);
      check_cw("random", 0, ref_encode(m));
      if (r == 0) begin
        saved_msg = m;
        for (int k = 0; k < TN; k++) saved_cw[k] = obs_q[k].sym;
      end
    end
  endtask

  task automatic test_gaps();
    msg_t m;
    m = rand_msg();
    obs_q.delete();
    ready_low = 0;
    drive(m, 1'b1, -1, TK);
    idle(10);
    wait_obs(TN);
    check_cw("gaps", 0, ref_encode(m));
    checks++;
    if (ready_low != TP) begin errors++; $display("FAIL gaps_ready_low: got %0d cycles expected %0d", ready_low, TP); end
  endtask

  task automatic test_back_to_back();
    msg_t m1;
    msg_t m2;
    int d;
    m1 = rand_msg();
    m2 = rand_msg();
    obs_q.delete();
    drive(m1, 1'b0, -1, TK);
    drive(m2, 1'b0, -1, TK);
    idle(8);
    wait_obs(2 * TN);
    check_cw("b2b_first", 0, ref_encode(m1));
    check_cw("b2b_second", TN, ref_encode(m2));
    d = obs_q[TN].c - obs_q[TN-1].c;
    checks++;
    if (d < 1 || d > 2) begin errors++; $display("FAIL b2b_gap: got %0d cycles expected 1..2", d); end
  endtask

  task automatic test_reset_mid();
    msg_t m;
    m = rand_msg();
    m[10] = 5'h1f;
    obs_q.delete();
    drive(m, 1'b0, -1, 11);
    @(negedge clock2);
    in_valid = 1'b0;
    in_start = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sym !== 5'd0) begin errors++; $display("FAIL midrst_out_sym: got %h expected 0", out_sym); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    @(negedge clock2);
    reset = 1'b1;
    obs_q.delete();
    idle(6);
    #1;
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL midrst_quiet: got %0d symbols expected 0", obs_q.size()); end
    drive(saved_msg, 1'b0, -1, TK);
    idle(8);
    wait_obs(TN);
    check_cw("midrst_next", 0, saved_cw);
    check_cw("midrst_ref", 0, ref_encode(saved_msg));
  endtask

  initial begin
    build_field();
    test_reset();
    test_idle_drop();
    test_zero_msg();
    test_unit_msg();
    test_random();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
